fetch_sequencer: RTL and testbench

//  Program-counter and fetch controller for the byte-addressed, registered-output instruction

---
 rtl/fetch_sequencer.sv | 122 ++++++++++++
 tb/tb_fetch_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for a 1-cycle-latency, word-per-4-bytes instruction memory.
// Tracks the single in-flight read, and handles stall replay, redirect squash, end-of-program halt and bad-target fault.
module fetch_sequencer #(
   parameter int ADDR_W    = 7,
   parameter int MEM_BYTES = 76,
   parameter int RESET_PC  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_data,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   output logic              halt,
   output logic              fault,
   output logic [15:0]       fetch_count
);

   localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(MEM_BYTES - 4);
   localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

   typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic              pend_reg, pend_next;
   logic [ADDR_W-1:0] pend_pc_reg, pend_pc_next;
   logic [15:0]       count_reg, count_next;

   logic accept;
   logic target_bad;

   // A redirect consumes whatever instruction is currently presented, even under stall.
   assign accept     = pend_reg & (~stall | redirect);
   assign target_bad = (redirect_addr[1:0] != 2'b00) || (redirect_addr > LAST_PC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         pc_reg      <= RESET_ADDR;
         pend_reg    <= 1'b0;
         pend_pc_reg <= '0;
         count_reg   <= 16'd0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         pend_reg    <= pend_next;
         pend_pc_reg <= pend_pc_next;
         count_reg   <= count_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      pend_next    = pend_reg;
      pend_pc_next = pend_pc_reg;
      count_next   = count_reg;

      if (accept && (count_reg != 16'hFFFF)) begin
         count_next = count_reg + 16'd1;
      end

      unique case (state_reg)
         IDLE: begin
            state_next = RUN;
         end
         RUN: begin
            if (redirect && target_bad) begin
               state_next = FAULT;
               pend_next  = 1'b0;
            end else if (redirect) begin
               // Squash the read of the old pc; the target issues next cycle.
               pc_next   = redirect_addr;
               pend_next = 1'b0;
            end else if (stall && pend_reg) begin
               pend_next = 1'b1;
            end else begin
               pend_next    = 1'b1;
               pend_pc_next = pc_reg;
               if (pc_reg == LAST_PC) begin
                  state_next = HALT;
               end else begin
                  pc_next = pc_reg + ADDR_W'(4);
               end
            end
         end
         HALT: begin
            if (redirect && target_bad) begin
               state_next = FAULT;
               pend_next  = 1'b0;
            end else if (redirect) begin
               state_next = RUN;
               pc_next    = redirect_addr;
               pend_next  = 1'b0;
            end else if (accept) begin
               pend_next = 1'b0;
            end
         end
         FAULT: begin
            state_next = FAULT;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // While stalled, replay the pending address so the memory keeps presenting the same word.
   assign mem_addr    = (stall && pend_reg) ? pend_pc_reg : pc_reg;
   assign instr       = mem_data;
   assign instr_pc    = pend_pc_reg;
   assign instr_valid = pend_reg;
   assign halt        = (state_reg == HALT);
   assign fault       = (state_reg == FAULT);
   assign fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a byte-addressed, big-endian, registered-output memory model.
module tb_fetch_sequencer;

   localparam int ADDR_W    = 7;
   localparam int MEM_BYTES = 76;

   logic              clk;
   logic              rst_n;
   logic              stall;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_addr;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_data;
   logic [31:0]       instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              halt;
   logic              fault;
   logic [15:0]       fetch_count;

   int n_cmp;
   int n_err;

   logic [7:0] mem_bytes [0:MEM_BYTES-1];

   fetch_sequencer #(
      .ADDR_W   (ADDR_W),
      .MEM_BYTES(MEM_BYTES),
      .RESET_PC (0)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_addr(redirect_addr),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .instr        (instr),
      .instr_pc     (instr_pc),
      .instr_valid  (instr_valid),
      .halt         (halt),
      .fault        (fault),
      .fetch_count  (fetch_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] word_k(input int k);
      return 32'hC0DE_0000 + 32'(k) * 32'h0000_0101;
   endfunction

   function automatic logic [31:0] rd_word(input logic [ADDR_W-1:0] a);
      int i;
      i = int'(a);
      if (i + 3 < MEM_BYTES)
         return {mem_bytes[i], mem_bytes[i+1], mem_bytes[i+2], mem_bytes[i+3]};
      return 32'h0;
   endfunction

   always @(posedge clk) mem_data <= rd_word(mem_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      stall    = 1'b0;
      redirect = 1'b0;
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({pfx, "_valid"}, 32'(instr_valid), 32'd0);
      check({pfx, "_pc"}, 32'(instr_pc), 32'd0);
      check({pfx, "_halt"}, 32'(halt), 32'd0);
      check({pfx, "_fault"}, 32'(fault), 32'd0);
      check({pfx, "_count"}, 32'(fetch_count), 32'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int k = 0; k < MEM_BYTES / 4; k++) begin
         logic [31:0] w;
         w = word_k(k);
         mem_bytes[4*k]   = w[31:24];
         mem_bytes[4*k+1] = w[23:16];
         mem_bytes[4*k+2] = w[15:8];
         mem_bytes[4*k+3] = w[7:0];
      end
      rst_n         = 1'b0;
      stall         = 1'b0;
      redirect      = 1'b0;
      redirect_addr = '0;
      #2;
      check_reset_outputs("rst");

      // Test 1: streaming from reset
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("t1_idle_valid", 32'(instr_valid), 32'd0);
      tick();
      check("t1_valid0", 32'(instr_valid), 32'd1);
      check("t1_pc0", 32'(instr_pc), 32'd0);
      check("t1_instr0", instr, word_k(0));
      check("t1_count0", 32'(fetch_count), 32'd0);
      for (int k = 1; k <= 2; k++) begin
         tick();
         check("t1_pc", 32'(instr_pc), 32'(4 * k));
         check("t1_instr", instr, word_k(k));
         check("t1_count", 32'(fetch_count), 32'(k));
      end

      // Test 2: 3-cycle stall at pc 8
      stall = 1'b1;
      #1;
      check("t2_replay_addr", 32'(mem_addr), 32'd8);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t2_instr", instr, word_k(2));
         check("t2_pc", 32'(instr_pc), 32'd8);
         check("t2_mem_addr", 32'(mem_addr), 32'd8);
         check("t2_count", 32'(fetch_count), 32'd2);
         check("t2_valid", 32'(instr_valid), 32'd1);
      end
      stall = 1'b0;
      tick();
      check("t2_pc_after", 32'(instr_pc), 32'd12);
      check("t2_instr_after", instr, word_k(3));
      check("t2_count_after", 32'(fetch_count), 32'd3);

      // Test 3: redirect to 0x20 while pc 8 is presented
      do_reset();
      for (int k = 0; k < 4; k++) tick();
      check("t3_pc_before", 32'(instr_pc), 32'd8);
      redirect      = 1'b1;
      redirect_addr = 7'h20;
      tick();
      redirect = 1'b0;
      check("t3_bubble_valid", 32'(instr_valid), 32'd0);
      check("t3_bubble_count", 32'(fetch_count), 32'd3);
      check("t3_bubble_addr", 32'(mem_addr), 32'h20);
      tick();
      check("t3_target_valid", 32'(instr_valid), 32'd1);
      check("t3_target_pc", 32'(instr_pc), 32'h20);
      check("t3_target_instr", instr, word_k(8));
      tick();
      check("t3_next_pc", 32'(instr_pc), 32'h24);

      // Test 4: run to the end, halt, then redirect out of halt
      for (int i = 0; i < 40 && !(instr_valid && instr_pc == 7'd72); i++) tick();
      check("t4_last_pc", 32'(instr_pc), 32'd72);
      check("t4_last_instr", instr, word_k(18));
      check("t4_halt_set", 32'(halt), 32'd1);
      tick();
      check("t4_halt_valid", 32'(instr_valid), 32'd0);
      check("t4_halt", 32'(halt), 32'd1);
      check("t4_count", 32'(fetch_count), 32'd14);
      tick();
      check("t4_halt_hold", 32'(halt), 32'd1);
      check("t4_halt_addr", 32'(mem_addr), 32'd72);
      redirect      = 1'b1;
      redirect_addr = 7'h10;
      tick();
      redirect = 1'b0;
      check("t4_unhalt", 32'(halt), 32'd0);
      check("t4_bubble_valid", 32'(instr_valid), 32'd0);
      tick();
      check("t4_resume_pc", 32'(instr_pc), 32'h10);
      check("t4_resume_instr", instr, word_k(4));
      check("t4_resume_count", 32'(fetch_count), 32'd14);

      // Test 5: illegal targets fault and stick
      do_reset();
      tick();
      redirect      = 1'b1;
      redirect_addr = 7'h22;
      tick();
      check("t5a_fault", 32'(fault), 32'd1);
      check("t5a_halt", 32'(halt), 32'd0);
      check("t5a_valid", 32'(instr_valid), 32'd0);
      redirect_addr = 7'h10;
      tick();
      tick();
      check("t5a_sticky", 32'(fault), 32'd1);
      check("t5a_valid_hold", 32'(instr_valid), 32'd0);
      check("t5a_addr_hold", 32'(mem_addr), 32'd0);
      check("t5a_count", 32'(fetch_count), 32'd0);
      redirect = 1'b0;
      do_reset();
      check("t5b_cleared", 32'(fault), 32'd0);
      tick();
      redirect      = 1'b1;
      redirect_addr = 7'h50;
      tick();
      redirect = 1'b0;
      check("t5b_fault", 32'(fault), 32'd1);
      check("t5b_valid", 32'(instr_valid), 32'd0);
      do_reset();
      tick();
      tick();
      redirect      = 1'b1;
      redirect_addr = 7'h4C;
      tick();
      redirect = 1'b0;
      check("t5c_fault_76", 32'(fault), 32'd1);
      check("t5c_valid", 32'(instr_valid), 32'd0);
      check("t5c_count", 32'(fetch_count), 32'd1);

      // Test 6: asynchronous reset mid-cycle while stalled
      do_reset();
      for (int k = 0; k < 3; k++) tick();
      stall = 1'b1;
      #1;
      check("t6_pre_addr", 32'(mem_addr), 32'd4);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t6");
      stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("t6_idle_valid", 32'(instr_valid), 32'd0);
      tick();
      check("t6_valid", 32'(instr_valid), 32'd1);
      check("t6_pc", 32'(instr_pc), 32'd0);
      check("t6_instr", instr, word_k(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
